// File: rtl/div_fu_if.sv
// DIV issue/result bundle between the pipeline control unit and the divider.
// Pure wiring, no latency of its own.
// No backpressure: the issuer owns timing, the divider answers a fixed number of cycles later.
interface div_fu_if;
    logic        EN;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] res;
    logic        res_valid;
    logic        busy;

    // Control unit side: issues operands, samples the result.
    modport master (
        output EN, op, rs1_data, rs2_data,
        input  res, res_valid, busy
    );

    // Divider side.
    modport slave (
        input  EN, op, rs1_data, rs2_data,
        output res, res_valid, busy
    );
endinterface

// File: rtl/div_fu.sv
// Fixed-latency DIV/DIVU/REM/REMU unit: radix-4 restoring core, then sign/special-case fixup.
// Result pulses exactly LATENCY cycles after the accept edge, for every operand pattern.
// No backpressure: accepts only when idle or in the result cycle; EN at other times is ignored.
module div_fu #(
    parameter int LATENCY = 24          // legal range 18..63
) (
    input  logic     clk,
    input  logic     rst_n,
    div_fu_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        WAIT,
        DONE
    } state_t;

    // 16 CALC cycles + 1 FIX cycle bring the counter to 17 before the first WAIT cycle.
    localparam logic [5:0] CALC_LAST = 6'd15;
    localparam logic [5:0] DONE_CNT  = 6'(LATENCY - 1);
    localparam logic [5:0] CNT_MAX   = 6'd63;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic        sa_q;          // dividend negative (signed ops only)
    logic        sb_q;          // divisor negative (signed ops only)
    logic [31:0] amag_q;        // |rs1|, kept intact for the special cases
    logic [31:0] bmag_q;        // |rs2|
    logic [31:0] quo_q;         // dividend shifts out the top, quotient bits enter the bottom
    logic [31:0] rem_q;         // partial remainder (always < divisor between steps)
    logic [31:0] result_q;      // internal result, published only at completion
    logic [31:0] res_q;
    logic        res_valid_q;
    logic        busy_q;

    logic        accept;
    logic        in_signed;
    logic [31:0] rs1_abs;
    logic [31:0] rs2_abs;
    logic [31:0] rem_s1, quo_s1;
    logic [31:0] rem_s2, quo_s2;
    logic [31:0] fix_res;

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    // The shifted remainder needs 33 bits; after a subtract the difference fits in 32.
    function automatic logic [63:0] div_step(input logic [31:0] r,
                                             input logic [31:0] q,
                                             input logic [31:0] d);
        logic [32:0] sh;
        logic [31:0] diff;
        sh   = {r, q[31]};
        diff = sh[31:0] - d;
        if (sh >= {1'b0, d}) begin
            div_step = {diff, q[30:0], 1'b1};
        end else begin
            div_step = {sh[31:0], q[30:0], 1'b0};
        end
    endfunction

    // Accept window and operand magnitudes for the issue cycle.
    always_comb begin
        accept    = bus.EN && ((state_q == IDLE) || (state_q == DONE));
        in_signed = ~bus.op[0];
        rs1_abs   = (in_signed && bus.rs1_data[31]) ? (32'd0 - bus.rs1_data) : bus.rs1_data;
        rs2_abs   = (in_signed && bus.rs2_data[31]) ? (32'd0 - bus.rs2_data) : bus.rs2_data;
    end

    // Two quotient bits per CALC cycle.
    always_comb begin
        {rem_s1, quo_s1} = div_step(rem_q, quo_q, bmag_q);
        {rem_s2, quo_s2} = div_step(rem_s1, quo_s1, bmag_q);
    end

    // Sign restoration and RISC-V divide-by-zero / overflow results.
    always_comb begin
        logic        is_rem;
        logic        is_signed;
        logic        div_zero;
        logic        ovf;
        logic [31:0] q_signed;
        logic [31:0] r_signed;
        logic [31:0] a_raw;

        is_rem    = op_q[1];
        is_signed = ~op_q[0];
        div_zero  = (bmag_q == 32'd0);
        ovf       = is_signed && sa_q && sb_q &&
                    (amag_q == 32'h8000_0000) && (bmag_q == 32'd1);
        q_signed  = (sa_q ^ sb_q) ? (32'd0 - quo_q) : quo_q;
        r_signed  = sa_q ? (32'd0 - rem_q) : rem_q;
        a_raw     = sa_q ? (32'd0 - amag_q) : amag_q;

        if (div_zero) begin
            fix_res = is_rem ? a_raw : 32'hFFFF_FFFF;
        end else if (ovf) begin
            fix_res = is_rem ? 32'd0 : 32'h8000_0000;
        end else begin
            fix_res = is_rem ? r_signed : q_signed;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            op_q        <= 2'd0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            amag_q      <= 32'd0;
            bmag_q      <= 32'd0;
            quo_q       <= 32'd0;
            rem_q       <= 32'd0;
            result_q    <= 32'd0;
            res_q       <= 32'd0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;

            if (busy_q && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 6'd1;
            end

            if (accept) begin
                op_q    <= bus.op;
                sa_q    <= in_signed && bus.rs1_data[31];
                sb_q    <= in_signed && bus.rs2_data[31];
                amag_q  <= rs1_abs;
                bmag_q  <= rs2_abs;
                quo_q   <= rs1_abs;
                rem_q   <= 32'd0;
                cnt_q   <= 6'd0;
                busy_q  <= 1'b1;
                state_q <= CALC;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    CALC: begin
                        rem_q <= rem_s2;
                        quo_q <= quo_s2;
                        if (cnt_q == CALC_LAST) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        result_q <= fix_res;
                        state_q  <= WAIT;
                    end
                    WAIT: begin
                        if (cnt_q == DONE_CNT) begin
                            res_q       <= result_q;
                            res_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;

endmodule
